dl_pipe_chain: RTL and testbench

- Parametrised successor to the single-bit dl_dff: a chain of DEPTH pipeline register stages, each WIDTH bits wide.
- Carries a per-stage valid bit and a valid/ready handshake, so stalls apply backpressure.
- Bubbles collapse: an empty stage accepts data even while the stage downstream of it is stalled.
- Standard delay/retiming element between core pipeline units and for balancing path latency in the datapath.

---
 rtl/dl_pipe_chain.sv | 104 ++++++++++
 tb/tb_dl_pipe_chain.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_pipe_chain.sv
// dl_pipe_chain: DEPTH-stage valid/ready register chain with bubble collapse.
// Optional occupancy output enabled by defining DL_PIPE_CHAIN_OCC_EN.
module dl_pipe_chain #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef DL_PIPE_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0]            v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q;
  logic [DEPTH-1:0][WIDTH-1:0] d_d;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH:0]              vin;
  logic [DEPTH:0][WIDTH-1:0]   din;

  // Upstream view of each stage: index 0 is the chain input.
  assign vin = {v_q, in_valid};
  assign din = {d_q, in_data};

  // Ready ripples back from the output; an empty stage is always ready.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc    = ~v_q[i] | acc;
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = d_q[DEPTH-1];

  // Next state: ready stages advance, data only on a valid beat.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!flush && rdy[i]) begin
        v_d[i] = vin[i];
        if (vin[i]) begin
          d_d[i] = din[i];
        end
      end
    end
    if (flush) begin
      v_d = '0;
    end
  end

  // Stage registers; flush clears valids but leaves data in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= {DEPTH{RESET_VAL}};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

`ifdef DL_PIPE_CHAIN_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Occupancy is the population count of the next valid vector.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + OCC_W'(v_d[i]);
    end
  end

  // Occupancy register tracks the valid bits edge for edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dl_pipe_chain.sv
// tb_dl_pipe_chain: directed checks of dl_pipe_chain (WIDTH=8, DEPTH=3).
// Occupancy checks are active when DL_PIPE_CHAIN_OCC_EN is defined.
module tb_dl_pipe_chain;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
`ifdef DL_PIPE_CHAIN_OCC_EN
  logic [1:0] occ;
`endif

  int checks = 0;
  int errors = 0;

  dl_pipe_chain #(
    .WIDTH(8),
    .DEPTH(3),
    .RESET_VAL(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready)
`ifdef DL_PIPE_CHAIN_OCC_EN
    ,
    .occ(occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_occ(input string tag, input logic [7:0] exp);
`ifdef DL_PIPE_CHAIN_OCC_EN
    check(tag, 8'(occ), exp);
`else
    if (exp > 8'd3) begin
      check(tag, exp, 8'd3);
    end
`endif
  endtask

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the input side, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [7:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ov", 8'(out_valid), 8'h0);
    check("rst_od", out_data, 8'h00);
    check("rst_ir", 8'(in_ready), 8'h1);
    check_occ("rst_occ", 8'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Streaming with out_ready held high.
    drive(1'b1, 8'h11, 1'b1);
    check("st_ir1", 8'(in_ready), 8'h1);
    check("st_ov1", 8'(out_valid), 8'h0);
    tick();
    drive(1'b1, 8'h22, 1'b1);
    check("st_ir2", 8'(in_ready), 8'h1);
    check("st_ov2", 8'(out_valid), 8'h0);
    tick();
    drive(1'b1, 8'h33, 1'b1);
    check("st_ir3", 8'(in_ready), 8'h1);
    check("st_ov3", 8'(out_valid), 8'h0);
    tick();
    drive(1'b1, 8'h44, 1'b1);
    check("st_ir4", 8'(in_ready), 8'h1);
    check("st_ov4", 8'(out_valid), 8'h1);
    check("st_od4", out_data, 8'h11);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    check("st_ov5", 8'(out_valid), 8'h1);
    check("st_od5", out_data, 8'h22);
    tick();
    check("st_od6", out_data, 8'h33);
    tick();
    check("st_od7", out_data, 8'h44);
    tick();
    check("st_ov8", 8'(out_valid), 8'h0);
    check("st_hold", out_data, 8'h44);
    check_occ("st_occ", 8'd0);

    // Stall, fill through bubbles, then drain.
    drive(1'b1, 8'hA1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check("sf_ov", 8'(out_valid), 8'h1);
    check("sf_od", out_data, 8'hA1);
    drive(1'b1, 8'hA2, 1'b0);
    check("sf_ir_a2", 8'(in_ready), 8'h1);
    tick();
    drive(1'b1, 8'hA3, 1'b0);
    check("sf_ir_a3", 8'(in_ready), 8'h1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    check("sf_full_ir", 8'(in_ready), 8'h0);
    check("sf_full_od", out_data, 8'hA1);
    check_occ("sf_occ3", 8'd3);
    tick();
    check("sf_hold_od", out_data, 8'hA1);
    drive(1'b0, 8'h00, 1'b1);
    check("sf_rdy_ir", 8'(in_ready), 8'h1);
    check("sf_dr_a1", out_data, 8'hA1);
    tick();
    check("sf_dr_a2", out_data, 8'hA2);
    check_occ("sf_occ2", 8'd2);
    tick();
    check("sf_dr_a3", out_data, 8'hA3);
    check_occ("sf_occ1", 8'd1);
    tick();
    check("sf_dr_end", 8'(out_valid), 8'h0);
    check_occ("sf_occ0", 8'd0);

    // Simultaneous leave and enter on a full chain.
    drive(1'b1, 8'hB1, 1'b0);
    tick();
    drive(1'b1, 8'hB2, 1'b0);
    tick();
    drive(1'b1, 8'hB3, 1'b0);
    tick();
    drive(1'b1, 8'hB4, 1'b0);
    check("si_full_ir", 8'(in_ready), 8'h0);
    check("si_full_od", out_data, 8'hB1);
    drive(1'b1, 8'hB4, 1'b1);
    check("si_ir", 8'(in_ready), 8'h1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    check("si_od_b2", out_data, 8'hB2);
    check_occ("si_occ3", 8'd3);
    tick();
    check("si_od_b3", out_data, 8'hB3);
    tick();
    check("si_od_b4", out_data, 8'hB4);
    check("si_ov_b4", 8'(out_valid), 8'h1);
    tick();
    check("si_end", 8'(out_valid), 8'h0);

    // Flush with two beats held.
    drive(1'b1, 8'hD1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b1, 8'hD2, 1'b0);
    tick();
    check("fl_pre_ov", 8'(out_valid), 8'h1);
    flush = 1'b1;
    drive(1'b1, 8'hD3, 1'b1);
    check("fl_ir", 8'(in_ready), 8'h0);
    check("fl_ov", 8'(out_valid), 8'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    check("fl_post_ov", 8'(out_valid), 8'h0);
    check("fl_post_ir", 8'(in_ready), 8'h1);
    check_occ("fl_occ", 8'd0);
    tick();
    check("fl_gone1", 8'(out_valid), 8'h0);
    tick();
    check("fl_gone2", 8'(out_valid), 8'h0);

    // Reset mid-flight, then normal latency after release.
    drive(1'b1, 8'hC1, 1'b0);
    tick();
    drive(1'b1, 8'hC2, 1'b0);
    tick();
    drive(1'b1, 8'hC3, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    check("rm_pre_ov", 8'(out_valid), 8'h1);
    rst_n = 1'b0;
    #1;
    check("rm_ov", 8'(out_valid), 8'h0);
    check("rm_od", out_data, 8'h00);
    check_occ("rm_occ", 8'd0);
    #1 rst_n = 1'b1;
    tick();
    drive(1'b1, 8'hC0, 1'b1);
    check("rm_ir", 8'(in_ready), 8'h1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    check("rm_lat1", 8'(out_valid), 8'h0);
    tick();
    check("rm_lat2", 8'(out_valid), 8'h0);
    tick();
    check("rm_ov_c0", 8'(out_valid), 8'h1);
    check("rm_od_c0", out_data, 8'hC0);
    tick();
    check("rm_end", 8'(out_valid), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
